// File: rtl/booth_multiplier.sv
// ============================================================================
// Module   : booth_multiplier
// Purpose  : Multicycle signed Booth multiplier with registered 2*WIDTH result,
//            overflow flag, busy level and one-cycle ready pulse.
//            Define BOOTH_MULT_RADIX4_EN for radix-4 (WIDTH/2 cycles);
//            radix-2 (WIDTH cycles) otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] product_hi,
  output logic             overflow,
  output logic             busy,
  output logic             ready
);

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int ACC_W = WIDTH + 2;
  localparam int STEPS = WIDTH / 2;
`else
  localparam int ACC_W = WIDTH + 1;
  localparam int STEPS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               last_step;

  logic [WIDTH-1:0]   a_reg;
  logic [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic               q_m1;
  logic [CNT_W-1:0]   count;

  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               q_m1_next;
  logic [2*WIDTH-1:0] full;
  logic               ovf_next;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (count == LAST) begin
          state_next = DONE;
          last_step  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One Booth step: choose the digit, add into the accumulator, shift right.
  always_comb begin
    a_ext  = {{(ACC_W-WIDTH){a_reg[WIDTH-1]}}, a_reg};
    addend = '0;
`ifdef BOOTH_MULT_RADIX4_EN
    case ({q[1:0], q_m1})
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext << 1;
      3'b100:         addend = -(a_ext << 1);
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
    sum       = acc + addend;
    acc_next  = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
    q_next    = {sum[1:0], q[WIDTH-1:2]};
    q_m1_next = q[1];
`else
    case ({q[0], q_m1})
      2'b01:   addend = a_ext;
      2'b10:   addend = -a_ext;
      default: addend = '0;
    endcase
    sum       = acc + addend;
    acc_next  = {sum[ACC_W-1], sum[ACC_W-1:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
`endif
    full     = {acc_next[WIDTH-1:0], q_next};
    ovf_next = !((&full[2*WIDTH-1:WIDTH-1]) || !(|full[2*WIDTH-1:WIDTH-1]));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_reg      <= '0;
      acc        <= '0;
      q          <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
      product    <= '0;
      product_hi <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b0;
    end else begin
      busy  <= (state_next == RUN);
      ready <= (state_next == DONE);
      if (accept) begin
        a_reg <= multiplicand;
        q     <= multiplier;
        q_m1  <= 1'b0;
        acc   <= '0;
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        q     <= q_next;
        q_m1  <= q_m1_next;
        count <= count + 1'b1;
      end
      // Results change only on the step that enters DONE.
      if (last_step) begin
        product    <= full[WIDTH-1:0];
        product_hi <= full[2*WIDTH-1:WIDTH];
        overflow   <= ovf_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_multiplier.sv
// ============================================================================
// Module   : tb_booth_multiplier
// Purpose  : Self-checking bench for booth_multiplier against a signed
//            arithmetic reference; honours BOOTH_MULT_RADIX4_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_multiplier;
  localparam int W = 32;
`ifdef BOOTH_MULT_RADIX4_EN
  localparam int L = W / 2;
`else
  localparam int L = W;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic [W-1:0] product;
  logic [W-1:0] product_hi;
  logic         overflow;
  logic         busy;
  logic         ready;

  int errors = 0;
  int checks = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .product_hi   (product_hi),
    .overflow     (overflow),
    .busy         (busy),
    .ready        (ready)
  );

  always #5 clock = ~clock;

  // Reference: exact signed product and its representability in W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  // Issues one start and counts edges until ready is seen (-1 on timeout).
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clock);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 4 * L; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({product, product_hi, overflow, busy, ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d got prod=%h hi=%h ovf=%b busy=%b rdy=%b want all 0",
                 i, product, product_hi, overflow, busy, ready);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [2*W-1:0] exp;
    do_mul(32'd7, 32'hFFFF_FFFD, lat);
    exp = ref_mul(32'd7, 32'hFFFF_FFFD);
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=%0d", lat, L);
    end
    checks++;
    if ({product_hi, product, overflow} !== {exp, 1'b0} || product !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL basic_result got hi=%h lo=%h ovf=%b want hi=%h lo=%h ovf=0",
               product_hi, product, overflow, exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse_width got rdy=%b busy=%b want 0 0", ready, busy);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
    logic [W-1:0]   tb [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 32'h7FFF_FFFF};
    int lat;
    logic [2*W-1:0] exp;
    logic           eovf;
    for (int i = 0; i < 4; i++) begin
      do_mul(ta[i], tb[i], lat);
      exp  = ref_mul(ta[i], tb[i]);
      eovf = ref_ovf(ta[i], tb[i]);
      checks++;
      if (lat !== L || {product_hi, product, overflow} !== {exp, eovf}) begin
        errors++;
        $display("FAIL corner_%0d lat=%0d hi=%h lo=%h ovf=%b want lat=%0d hi=%h lo=%h ovf=%b",
                 i, lat, product_hi, product, overflow, L, exp[2*W-1:W], exp[W-1:0], eovf);
      end
    end
  endtask

  task automatic test_ignored_start();
    int rdy_count = 0;
    int rdy_at = -1;
    int early_drop = 0;
    @(negedge clock);
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    start        = 1'b1;
    @(posedge clock);
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clock);
      start        = (k == 3);
      multiplicand = (k == 3) ? 32'd9 : $urandom;
      multiplier   = (k == 3) ? 32'd9 : $urandom;
      if (k < L && busy !== 1'b1) early_drop++;
      if (ready) begin
        rdy_count++;
        if (rdy_at < 0) rdy_at = k;
      end
      @(posedge clock);
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (early_drop != 0) begin
      errors++;
      $display("FAIL ignored_busy got early_drops=%0d want 0", early_drop);
    end
    checks++;
    if (rdy_count != 1 || rdy_at != L) begin
      errors++;
      $display("FAIL ignored_ready got count=%0d at=%0d want count=1 at=%0d", rdy_count, rdy_at, L);
    end
    checks++;
    if (product !== 32'd30 || product_hi !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignored_product got lo=%h hi=%h ovf=%b want lo=1e hi=0 ovf=0",
               product, product_hi, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    @(negedge clock);
    multiplicand = 32'hFFFF_FFFE;
    multiplier   = 32'hFFFF_FFFE;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if ({product, product_hi, overflow, busy, ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got prod=%h hi=%h ovf=%b busy=%b rdy=%b want all 0",
               product, product_hi, overflow, busy, ready);
    end
    for (int k = 0; k < L + 2; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_no_ready got activity_cycles=%0d want 0", seen);
    end
    do_mul(32'd3, 32'd4, lat);
    checks++;
    if (lat !== L || product !== 32'd12 || product_hi !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_fresh got lat=%0d lo=%h hi=%h ovf=%b want lat=%0d lo=c hi=0 ovf=0",
               lat, product, product_hi, overflow, L);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap = -1;
    logic [2*W-1:0] exp;
    do_mul(32'd100, 32'hFFFF_FFF9, lat);
    exp = ref_mul(32'd100, 32'hFFFF_FFF9);
    checks++;
    if (lat !== L || {product_hi, product} !== exp) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
               lat, product_hi, product, L, exp[2*W-1:W], exp[W-1:0]);
    end
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    start        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b rdy=%b want busy=1 rdy=0", busy, ready);
    end
    for (int k = 2; k <= 4 * L; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready) begin
        gap = k;
        break;
      end
    end
    checks++;
    if (gap != L + 1 || product !== 32'd1 || product_hi !== 32'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got gap=%0d lo=%h hi=%h ovf=%b want gap=%0d lo=1 hi=0 ovf=0",
               gap, product, product_hi, overflow, L + 1);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    logic           eovf;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(0, 70000);
      if (i % 4 == 2) a = {{16{a[15]}}, a[15:0]};
      do_mul(a, b, lat);
      exp  = ref_mul(a, b);
      eovf = ref_ovf(a, b);
      checks++;
      if (lat !== L || {product_hi, product, overflow} !== {exp, eovf}) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h got lat=%0d hi=%h lo=%h ovf=%b want lat=%0d hi=%h lo=%h ovf=%b",
                 i, a, b, lat, product_hi, product, overflow, L, exp[2*W-1:W], exp[W-1:0], eovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
